addsub_seq_unit: RTL and testbench
==================================

ADDSUB_SEQ_UNIT -- requirements
Module: addsub_seq_unit

Interface
REQ-001 Parameter W, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 2, bits processed per cycle; W SHALL be an integer multiple of CHUNK; N = W/CHUNK.
REQ-003 Parameter SAT, default 0, 1 = signed saturation on overflow, 0 = two's-complement wrap.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand set valid.
REQ-007 in_ready  output  1  unit can accept operands.
REQ-008 op_sub  input  1  0 = X+Y, 1 = X-Y.
REQ-009 acc_mode  input  1  1 = internal accumulator replaces X.
REQ-010 x  input  W  operand X.
REQ-011 y  input  W  operand Y.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 s  output  W  result.
REQ-015 cout  output  1  unsigned carry-out (sub: 1 = no borrow).
REQ-016 ovf  output  1  signed overflow of unsaturated result.
REQ-017 busy  output  1  high in CALC or DONE.

Function
REQ-018 FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 IDLE: on in_valid=1, SHALL capture A = (acc_mode ? acc : x), B = y ^ {W{op_sub}}, carry = op_sub, slice index = 0, and go to CALC.
REQ-020 CALC: each cycle SHALL add slice [i*CHUNK +: CHUNK] of A, B and carry, store the slice sum, update carry, increment i; after slice N-1, go to DONE.
REQ-021 Latency: accept edge E0, slices at edges E1..EN; out_valid SHALL be first high in the cycle after EN (N+1 cycles after acceptance); no new operand accepted before the result handshake.
REQ-022 On entering DONE: cout = final carry; ovf = (A[W-1] == B[W-1]) && (raw_sum[W-1] != A[W-1]).
REQ-023 s = raw_sum when SAT=0 or ovf=0; when SAT=1 and ovf=1, s = 0111..1 if A[W-1]=0, else 1000..0.
REQ-024 DONE: s, cout, ovf SHALL hold stable while out_ready=0; on out_ready=1, SHALL load acc <= s and go to IDLE.
REQ-025 In IDLE and CALC, s, cout, ovf SHALL retain last delivered values (zero after reset).
REQ-026 in_valid during CALC/DONE SHALL be ignored; x, y, op_sub, acc_mode SHALL only be sampled at the accept edge.
REQ-027 acc SHALL change only on result handshake or reset; back-to-back acc_mode operations SHALL chain results.
REQ-028 Parameter combination violating REQ-001/002 SHALL cause elaboration failure.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, acc=0, s=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 next cycle, overriding any other event.
REQ-030 rst asserted during CALC or DONE SHALL discard the operation with no result delivered and acc=0.

Verification (W=8, CHUNK=2)
REQ-031 add x=100, y=27, SAT=0 -> s=0x7F, cout=0, ovf=0; out_valid exactly 5 cycles after accept edge.
REQ-032 add x=100, y=28 -> SAT=0: s=0x80, ovf=1, cout=0; SAT=1: s=0x7F, ovf=1.
REQ-033 sub x=5, y=9 -> s=0xFC, cout=0, ovf=0; sub x=0x80, y=0x01 -> s=0x7F, cout=1, ovf=1 (SAT=1: s=0x80).
REQ-034 out_ready held low 3 cycles in DONE, in_valid pulsed meanwhile -> s/flags stable, in_ready=0, pulse ignored; accept on 4th cycle, then IDLE.
REQ-035 acc_mode: add 10 (acc=0), then add y=5, then sub y=20 -> s=10, 15, 0xFB; acc=0xFB.
REQ-036 rst at 2nd CALC cycle -> next cycle IDLE, out_valid=0, acc=0, s=0; following add 1+1 -> s=2.

Source files
------------

// File: rtl/addsub_seq_unit.sv
// Sequential adder/subtractor: CHUNK bits per cycle with ripple carry held in a register,
// optional signed saturation and an internal accumulator that can stand in for operand X.
module addsub_seq_unit #(
   parameter int W     = 8,
   parameter int CHUNK = 2,
   parameter int SAT   = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         op_sub,
   input  logic         acc_mode,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         ovf,
   output logic         busy
);

   localparam int  N      = (CHUNK > 0) ? W / CHUNK : 1;
   localparam int  IW     = (N > 1) ? $clog2(N) : 1;
   localparam bit  SAT_EN = (SAT != 0);

   generate
      if (W < 2 || CHUNK < 1 || (W % CHUNK) != 0) begin : g_param_err
         $error("addsub_seq_unit: W must be >= 2 and an integer multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            carry_q, carry_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    sum_q, sum_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [W-1:0]    s_q, s_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic [CHUNK-1:0] a_slices [N];
   logic [CHUNK-1:0] b_slices [N];
   logic [CHUNK-1:0] a_sl, b_sl;
   logic [CHUNK:0]   sl_sum;
   logic [W-1:0]     raw_sum;
   logic [W-1:0]     sat_val;
   logic             ovf_raw;
   logic             last_slice;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_slice
         assign a_slices[gi] = a_q[gi*CHUNK +: CHUNK];
         assign b_slices[gi] = b_q[gi*CHUNK +: CHUNK];
      end
   endgenerate

   // Datapath for the slice currently being processed; raw_sum already includes it.
   always_comb begin
      a_sl       = a_slices[idx_q];
      b_sl       = b_slices[idx_q];
      sl_sum     = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
      raw_sum    = sum_q;
      raw_sum[int'(idx_q)*CHUNK +: CHUNK] = sl_sum[CHUNK-1:0];
      ovf_raw    = (a_q[W-1] == b_q[W-1]) && (raw_sum[W-1] != a_q[W-1]);
      sat_val    = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      last_slice = (idx_q == IW'(N-1));
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      acc_d   = acc_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = acc_mode ? acc_q : x;
               b_d     = y ^ {W{op_sub}};
               carry_d = op_sub;
               idx_d   = '0;
               sum_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            sum_d   = raw_sum;
            carry_d = sl_sum[CHUNK];
            idx_d   = idx_q + 1'b1;
            if (last_slice) begin
               idx_d   = '0;
               cout_d  = sl_sum[CHUNK];
               ovf_d   = ovf_raw;
               s_d     = (SAT_EN && ovf_raw) ? sat_val : raw_sum;
               state_d = DONE;
            end
         end
         DONE: begin
            // Result registers stay frozen until the consumer takes them.
            if (out_ready) begin
               acc_d   = s_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         acc_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_seq_unit.sv
// Scoreboard bench: a wrapping (SAT=0) and a saturating (SAT=1) instance share one stimulus stream.
module tb_addsub_seq_unit;

   localparam int W = 8;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         op_sub = 1'b0;
   logic         acc_mode = 1'b0;
   logic [W-1:0] x = '0;
   logic [W-1:0] y = '0;
   logic         out_ready = 1'b1;

   logic         in_ready0, out_valid0, cout0, ovf0, busy0;
   logic         in_ready1, out_valid1, cout1, ovf1, busy1;
   logic [W-1:0] s0, s1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   addsub_seq_unit #(.W(W), .CHUNK(2), .SAT(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .op_sub(op_sub), .acc_mode(acc_mode), .x(x), .y(y),
      .out_valid(out_valid0), .out_ready(out_ready), .s(s0),
      .cout(cout0), .ovf(ovf0), .busy(busy0)
   );

   addsub_seq_unit #(.W(W), .CHUNK(2), .SAT(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .op_sub(op_sub), .acc_mode(acc_mode), .x(x), .y(y),
      .out_valid(out_valid1), .out_ready(out_ready), .s(s1),
      .cout(cout1), .ovf(ovf1), .busy(busy1)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: pops the scoreboard on every result handshake of either instance.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
               chk("dut0_unexpected_result", 32'(s0), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = q0.pop_front();
               $display("[TB] dut0 result s=%02h cout=%0b ovf=%0b (exp %02h %0b %0b)",
                        s0, cout0, ovf0, e.s, e.c, e.o);
               chk("dut0_s", 32'(s0), 32'(e.s));
               chk("dut0_cout", 32'(cout0), 32'(e.c));
               chk("dut0_ovf", 32'(ovf0), 32'(e.o));
            end
         end
         if (out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
               chk("dut1_unexpected_result", 32'(s1), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = q1.pop_front();
               $display("[TB] dut1 result s=%02h cout=%0b ovf=%0b (exp %02h %0b %0b)",
                        s1, cout1, ovf1, e.s, e.c, e.o);
               chk("dut1_s", 32'(s1), 32'(e.s));
               chk("dut1_cout", 32'(cout1), 32'(e.c));
               chk("dut1_ovf", 32'(ovf1), 32'(e.o));
            end
         end
      end
   end

   // Issue one operation and wait for out_valid; latency is the number of edges
   // after the accept edge until out_valid is seen (slices at E1..EN).
   task automatic issue(input logic sub, input logic accm,
                        input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic [W-1:0] e0s, input logic e0c, input logic e0o,
                        input logic [W-1:0] e1s, input logic e1c, input logic e1o,
                        input bit handshake);
      int cnt;
      exp_t e;
      cnt = 0;
      while (!in_ready0 && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("in_ready_before_issue", 32'(in_ready0), 32'd1);
      op_sub   = sub;
      acc_mode = accm;
      x        = xv;
      y        = yv;
      in_valid = 1'b1;
      e.s = e0s; e.c = e0c; e.o = e0o; q0.push_back(e);
      e.s = e1s; e.c = e1c; e.o = e1o; q1.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      x        = 8'h5A;
      y        = 8'hA5;
      op_sub   = ~sub;
      acc_mode = ~accm;
      cnt = 0;
      while (!out_valid0 && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("latency_edges", 32'(cnt), 32'(N));
      chk("dut1_out_valid_lockstep", 32'(out_valid1), 32'd1);
      if (handshake) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_in_ready", 32'(in_ready0), 32'd1);
      chk("rst_out_valid", 32'(out_valid0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_s", 32'(s0), 32'd0);
      chk("rst_cout_ovf", 32'({cout0, ovf0}), 32'd0);

      // 100+27 = 127: no overflow either way
      issue(1'b0, 1'b0, 8'd100, 8'd27, 8'h7F, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1);
      // 100+28 overflows positive: wrap to 0x80, saturate to 0x7F
      issue(1'b0, 1'b0, 8'd100, 8'd28, 8'h80, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1);
      // 5-9 = -4, borrow so cout=0
      issue(1'b1, 1'b0, 8'd5, 8'd9, 8'hFC, 1'b0, 1'b0, 8'hFC, 1'b0, 1'b0, 1);
      // -128-1 overflows negative: wrap 0x7F, saturate 0x80, no borrow
      issue(1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 1);

      // Stall in DONE for 3 cycles with an in_valid pulse that must be ignored
      out_ready = 1'b0;
      issue(1'b0, 1'b0, 8'd3, 8'd4, 8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("stall_s", 32'(s0), 32'h07);
         chk("stall_flags", 32'({cout0, ovf0}), 32'd0);
         chk("stall_in_ready", 32'(in_ready0), 32'd0);
         chk("stall_out_valid", 32'(out_valid0), 32'd1);
         if (i == 1) begin
            x = 8'hAA; y = 8'h11; op_sub = 1'b0; acc_mode = 1'b0;
            in_valid = 1'b1;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      chk("stall_s_final", 32'(s0), 32'h07);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_stall_in_ready", 32'(in_ready0), 32'd1);
      chk("post_stall_out_valid", 32'(out_valid0), 32'd0);
      chk("post_stall_busy", 32'(busy0), 32'd0);

      // Accumulator chaining from a fresh reset
      do_reset();
      issue(1'b0, 1'b1, 8'h55, 8'd10, 8'd10, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0, 1);
      issue(1'b0, 1'b1, 8'h33, 8'd5, 8'd15, 1'b0, 1'b0, 8'd15, 1'b0, 1'b0, 1);
      issue(1'b1, 1'b1, 8'h77, 8'd20, 8'hFB, 1'b0, 1'b0, 8'hFB, 1'b0, 1'b0, 1);
      issue(1'b0, 1'b1, 8'h00, 8'd0, 8'hFB, 1'b0, 1'b0, 8'hFB, 1'b0, 1'b0, 1);

      // Reset in the second CALC cycle discards the operation and clears acc
      x = 8'd50; y = 8'd60; op_sub = 1'b0; acc_mode = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("midrst_busy_calc", 32'(busy0), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_in_ready", 32'(in_ready0), 32'd1);
      chk("midrst_out_valid", 32'(out_valid0), 32'd0);
      chk("midrst_s", 32'(s0), 32'd0);
      chk("midrst_busy", 32'(busy0), 32'd0);
      issue(1'b0, 1'b1, 8'hEE, 8'd1, 8'd1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1);
      issue(1'b0, 1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard0_drained", 32'(q0.size()), 32'd0);
      chk("scoreboard1_drained", 32'(q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
